// File: rtl/mulcyc_mul.sv
// -----------------------------------------------------------------------------
// mulcyc_mul -- iterative shift-add multiplier (one multiplier bit per cycle)
//
// Supports mul / mulh / mulhsu / mulhu through the sign_a / sign_b qualifiers.
// The operands are reduced to unsigned magnitudes and multiplied. The result
// is then negated if exactly one operand was negative.
//
// Ports
//   clk           sole clock, rising edge
//   rst           asynchronous, active-high reset
//   start         request a multiply (sampled only in IDLE)
//   flush         abort the in-flight operation (ignored in FINISH)
//   stall         downstream not ready; holds FINISH
//   sign_a/sign_b treat MULTIPLICAND / MULTIPLIER as signed when 1
//   MULTIPLICAND  operand A, MUL_WIDTH bits
//   MULTIPLIER    operand B, MUL_WIDTH bits
//   PROD_LO/HI    low / high halves of the 2*MUL_WIDTH product
//   mul_idle      high in IDLE or FINISH
//   calc_done     registered; high in every FINISH cycle
//
// Configuration
//   MULCYC_MUL_EARLY_OUT_EN  when defined, CALC exits as soon as the remaining
//                            multiplier bits are all zero. Results are the
//                            same in both builds; only the latency changes.
// -----------------------------------------------------------------------------
module mulcyc_mul #(
    parameter int MUL_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 flush,
    input  logic                 stall,
    input  logic                 sign_a,
    input  logic                 sign_b,
    input  logic [MUL_WIDTH-1:0] MULTIPLICAND,
    input  logic [MUL_WIDTH-1:0] MULTIPLIER,
    output logic [MUL_WIDTH-1:0] PROD_LO,
    output logic [MUL_WIDTH-1:0] PROD_HI,
    output logic                 mul_idle,
    output logic                 calc_done
);

    localparam int CNT_W = $clog2(MUL_WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        DONE   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t                   state_reg;
    logic [2*MUL_WIDTH-1:0]   mcand_reg;   // multiplicand magnitude, shifted left each step
    logic [2*MUL_WIDTH-1:0]   acc_reg;     // running sum of partial products
    logic [MUL_WIDTH-1:0]     mplier_reg;  // multiplier magnitude, shifted right each step
    logic [CNT_W-1:0]         cnt_reg;
    logic                     neg_reg;     // final product must be negated

    // Operand conditioning. The magnitude of the most-negative value,
    // 2^(MUL_WIDTH-1), still fits in an unsigned MUL_WIDTH-bit field. The
    // unary minus therefore gives the exact magnitude for every input.
    logic                     a_neg;
    logic                     b_neg;
    logic [MUL_WIDTH-1:0]     a_mag;
    logic [MUL_WIDTH-1:0]     b_mag;
    logic [MUL_WIDTH-1:0]     mplier_shifted;
    logic                     last_step;
    logic [2*MUL_WIDTH-1:0]   acc_signed;

    assign a_neg = sign_a & MULTIPLICAND[MUL_WIDTH-1];
    assign b_neg = sign_b & MULTIPLIER[MUL_WIDTH-1];
    assign a_mag = a_neg ? (-MULTIPLICAND) : MULTIPLICAND;
    assign b_mag = b_neg ? (-MULTIPLIER) : MULTIPLIER;

    assign mplier_shifted = mplier_reg >> 1;

`ifdef MULCYC_MUL_EARLY_OUT_EN
    // Once the remaining multiplier bits are zero, no more partial products
    // can contribute to the sum.
    assign last_step = (cnt_reg == LAST_STEP) || (mplier_shifted == '0);
`else
    assign last_step = (cnt_reg == LAST_STEP);
`endif

    // Negating zero gives zero, so a zero product always stays zero.
    assign acc_signed = neg_reg ? (-acc_reg) : acc_reg;

    assign mul_idle = (state_reg == IDLE) || (state_reg == FINISH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            mcand_reg  <= '0;
            acc_reg    <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            neg_reg    <= 1'b0;
            PROD_LO    <= '0;
            PROD_HI    <= '0;
            calc_done  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Operands are re-captured every idle cycle. The start
                    // cycle therefore always latches the current inputs.
                    mcand_reg  <= {{MUL_WIDTH{1'b0}}, a_mag};
                    mplier_reg <= b_mag;
                    neg_reg    <= a_neg ^ b_neg;
                    acc_reg    <= '0;
                    cnt_reg    <= '0;
                    calc_done  <= 1'b0;
                    if (start && !flush) begin
                        state_reg <= CALC;
                    end
                end

                CALC: begin
                    if (mplier_reg[0]) begin
                        acc_reg <= acc_reg + mcand_reg;
                    end
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_shifted;
                    cnt_reg    <= cnt_reg + CNT_W'(1);
                    if (flush) begin
                        state_reg <= IDLE;
                    end else if (last_step) begin
                        state_reg <= DONE;
                    end
                end

                DONE: begin
                    if (flush) begin
                        // Aborted: leave the previous product visible.
                        state_reg <= IDLE;
                    end else begin
                        PROD_HI   <= acc_signed[2*MUL_WIDTH-1:MUL_WIDTH];
                        PROD_LO   <= acc_signed[MUL_WIDTH-1:0];
                        calc_done <= 1'b1;
                        state_reg <= FINISH;
                    end
                end

                FINISH: begin
                    // start and flush are deliberately ignored here. Only
                    // the consumer can release the result.
                    if (!stall) begin
                        calc_done <= 1'b0;
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mulcyc_mul.sv
// -----------------------------------------------------------------------------
// tb_mulcyc_mul -- self-checking bench for mulcyc_mul (MUL_WIDTH = 32)
//
// The bench applies a vector table of directed products, then hand-written
// sequences for flush, stall, start+flush, and asynchronous reset, then
// randomized operands. It checks every result against a 64-bit arithmetic
// reference computed here.
// -----------------------------------------------------------------------------
module tb_mulcyc_mul;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic         flush;
    logic         stall;
    logic         sign_a;
    logic         sign_b;
    logic [W-1:0] MULTIPLICAND;
    logic [W-1:0] MULTIPLIER;
    logic [W-1:0] PROD_LO;
    logic [W-1:0] PROD_HI;
    logic         mul_idle;
    logic         calc_done;

    int checks = 0;
    int errors = 0;

    mulcyc_mul #(.MUL_WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .flush        (flush),
        .stall        (stall),
        .sign_a       (sign_a),
        .sign_b       (sign_b),
        .MULTIPLICAND (MULTIPLICAND),
        .MULTIPLIER   (MULTIPLIER),
        .PROD_LO      (PROD_LO),
        .PROD_HI      (PROD_HI),
        .mul_idle     (mul_idle),
        .calc_done    (calc_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sa;
        logic         sb;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference product: sign- or zero-extend to 64 bits and multiply mod 2^64.
    function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sa, input logic sb);
        logic [63:0] ae;
        logic [63:0] be;
        ae = (sa && a[W-1]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
        be = (sb && b[W-1]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
        return ae * be;
    endfunction

    // Expected cycles from the start-sampling edge to the first calc_done
    // cycle: the CALC cycles, plus DONE, plus the first FINISH cycle.
    function automatic int ref_latency(input logic [W-1:0] b, input logic sb);
        logic [W-1:0] mag;
        int           k;
        mag = (sb && b[W-1]) ? (-b) : b;
        k = 0;
        for (int i = 0; i < W; i++) begin
            if (mag[i]) k = i + 1;
        end
`ifdef MULCYC_MUL_EARLY_OUT_EN
        if (k < 1) k = 1;
        return k + 2;
`else
        return W + 2;
`endif
    endfunction

    // Start one multiply and wait, with a bound, for calc_done. The inputs are
    // driven at the negedge. The cycle just after the sampling edge is cycle 1.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sa, input logic sb,
                          output logic [63:0] prod, output int lat);
        @(negedge clk);
        MULTIPLICAND = a;
        MULTIPLIER   = b;
        sign_a       = sa;
        sign_b       = sb;
        start        = 1'b1;
        lat          = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (calc_done === 1'b1) begin
                lat = c;
                break;
            end
        end
        prod = {PROD_HI, PROD_LO};
        if (lat < 0) chk("calc_done_timeout", 64'd0, 64'd1);
        $display("op a=%h b=%h sa=%0d sb=%0d prod=%h lat=%0d", a, b, sa, sb, prod, lat);
    endtask

    task automatic run_and_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sa, input logic sb, input logic [63:0] exp);
        logic [63:0] prod;
        int          lat;
        run_op(a, b, sa, sb, prod, lat);
        chk({name, "_prod"}, prod, exp);
        chk({name, "_lat"}, 64'(lat), 64'(ref_latency(b, sb)));
    endtask

    vec_t        vecs[12];
    logic [63:0] prod;
    logic [63:0] prev;
    int          lat;
    logic        seen_done;

    initial begin
        // The expected products here were worked out by hand, not by ref_prod.
        vecs[0]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 32'h4000_0000, 32'h0000_0000};
        vecs[3]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[4]  = '{32'h0000_0006, 32'h0000_0007, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_002A};
        vecs[5]  = '{32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_000F};
        vecs[6]  = '{32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
        vecs[7]  = '{32'hFFFF_FFFB, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000};
        vecs[8]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[9]  = '{32'h8000_0000, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0000};
        vecs[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0001};
        vecs[11] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 32'hC000_0000, 32'h8000_0000};

        rst          = 1'b1;
        start        = 1'b0;
        flush        = 1'b0;
        stall        = 1'b0;
        sign_a       = 1'b0;
        sign_b       = 1'b0;
        MULTIPLICAND = '0;
        MULTIPLIER   = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_prod", {PROD_HI, PROD_LO}, 64'd0);
        chk("reset_calc_done", 64'(calc_done), 64'd0);
        chk("reset_mul_idle", 64'(mul_idle), 64'd1);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb,
                          {vecs[i].exp_hi, vecs[i].exp_lo});
        end

        // Flush on the 10th CALC cycle
        @(negedge clk);
        prev = {PROD_HI, PROD_LO};
        MULTIPLICAND = 32'h0000_FFFF;
        MULTIPLIER   = 32'h0000_FFFF;
        sign_a = 1'b0;
        sign_b = 1'b0;
        start  = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 1) chk("flush_in_calc", 64'(mul_idle), 64'd0);
            if (c == 10) flush = 1'b1;
        end
        @(negedge clk);
        flush = 1'b0;
        chk("flush_to_idle", 64'(mul_idle), 64'd1);
        seen_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (calc_done !== 1'b0 || mul_idle !== 1'b1) seen_done = 1'b1;
        end
        chk("flush_no_done", 64'(seen_done), 64'd0);
        chk("flush_prod_kept", {PROD_HI, PROD_LO}, prev);
        $display("op flush at CALC cycle 10 prod=%h", {PROD_HI, PROD_LO});
        run_and_check("after_flush", 32'd6, 32'd7, 1'b0, 1'b0, 64'd42);

        // start together with flush in IDLE must not launch
        @(negedge clk);
        MULTIPLICAND = 32'd9;
        MULTIPLIER   = 32'd9;
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (mul_idle !== 1'b1) seen_done = 1'b1;
            @(negedge clk);
        end
        chk("start_flush_stays_idle", 64'(seen_done), 64'd0);
        $display("op start+flush in IDLE ignored");

        // Stall held 5 cycles in FINISH. start and flush are ignored there.
        stall = 1'b1;
        run_op(32'd1000, 32'd3000, 1'b0, 1'b0, prod, lat);
        chk("stall_prod", prod, 64'd3000000);
        seen_done = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (calc_done !== 1'b1 || mul_idle !== 1'b1 || {PROD_HI, PROD_LO} !== prod)
                seen_done = 1'b1;
            if (i == 6) begin
                stall = 1'b0;
                start = 1'b0;
                flush = 1'b0;
            end else begin
                MULTIPLICAND = 32'd77;
                MULTIPLIER   = 32'd77;
                start = 1'b1;
                flush = (i == 3);
                @(negedge clk);
            end
        end
        chk("stall_hold_6", 64'(seen_done), 64'd0);
        @(negedge clk);
        chk("stall_release_done", 64'(calc_done), 64'd0);
        chk("stall_release_idle", 64'(mul_idle), 64'd1);
        @(negedge clk);
        chk("stall_start_ignored", 64'(mul_idle), 64'd1);
        $display("op stall 5 cycles prod=%h", {PROD_HI, PROD_LO});

        // Asynchronous reset mid-CALC: the clear is visible before any edge.
        @(negedge clk);
        MULTIPLICAND = 32'h1234_5678;
        MULTIPLIER   = 32'h0000_0003;
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("arst_calc_prod", {PROD_HI, PROD_LO}, 64'd0);
        chk("arst_calc_idle", 64'(mul_idle), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        run_and_check("after_arst_calc", 32'h0001_0001, 32'h0000_0010, 1'b0, 1'b0, 64'h0000_0000_0010_0010);

        // Asynchronous reset mid-FINISH
        stall = 1'b1;
        run_op(32'd12, 32'd12, 1'b0, 1'b0, prod, lat);
        rst = 1'b1;
        #1;
        chk("arst_finish_done", 64'(calc_done), 64'd0);
        chk("arst_finish_prod", {PROD_HI, PROD_LO}, 64'd0);
        stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_and_check("after_arst_finish", 32'hFFFF_FFF0, 32'h0000_0010, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF00);

        // Randomized operands against the arithmetic reference
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rsa;
            logic         rsb;
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(0, 7))
                0: ra = 32'h8000_0000;
                1: rb = 32'h8000_0000;
                2: rb = W'($urandom_range(0, 255));
                3: ra = '0;
                4: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            rsa = 1'($urandom_range(0, 1));
            rsb = 1'($urandom_range(0, 1));
            run_and_check($sformatf("rand%0d", n), ra, rb, rsa, rsb, ref_prod(ra, rb, rsa, rsb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
